// File: rtl/matrix_pkg.sv
// Shared unit codes, scheduler states and helpers for the matrix controller family.
package matrix_pkg;

  localparam int UNIT_WIDTH = 3;

  typedef logic [UNIT_WIDTH-1:0] unit_t;

  // Unit codes decoded by MatrixController; code 0 means "nothing addressed".
  localparam unit_t UNIT_NONE = 3'd0;
  localparam unit_t UNIT_A    = 3'd1;
  localparam unit_t UNIT_B    = 3'd2;
  localparam unit_t UNIT_C    = 3'd3;
  localparam unit_t UNIT_D    = 3'd4;
  localparam unit_t UNIT_E    = 3'd5;
  localparam unit_t UNIT_MAX  = UNIT_E;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE,
    ST_ERR
  } sched_state_e;

  // A unit code is dispatchable only if it names one of the real units A..E.
  function automatic logic unitIsLegal(input unit_t unit);
    return (unit >= UNIT_A) && (unit <= UNIT_MAX);
  endfunction

endpackage

// File: rtl/matrix_coord_counter.sv
// Raster-order x/y cell counter: x runs fastest, wraps to 0 and bumps y at xlast.
module matrix_coord_counter
  import matrix_pkg::*;
#(
  parameter int maxWidthLen = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear_i,
  input  logic                   advance_i,
  input  logic [maxWidthLen-1:0] xlast_i,
  input  logic [maxWidthLen-1:0] ylast_i,
  output logic [maxWidthLen-1:0] x_o,
  output logic [maxWidthLen-1:0] y_o,
  output logic                   last_o
);

  logic [maxWidthLen-1:0] x_q, x_d;
  logic [maxWidthLen-1:0] y_q, y_d;

  // Next cell: equality compare means x never runs past xlast, even at full width.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (clear_i) begin
      x_d = '0;
      y_d = '0;
    end else if (advance_i && !last_o) begin
      if (x_q != xlast_i) begin
        x_d = x_q + 1'b1;
      end else begin
        x_d = '0;
        y_d = y_q + 1'b1;
      end
    end
  end

  // Coordinate registers, cleared by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x_o    = x_q;
  assign y_o    = y_q;
  assign last_o = (x_q == xlast_i) && (y_q == ylast_i);

endmodule

// File: rtl/matrix_sweep_scheduler.sv
// Walks a rectangle of cells in raster order, dispatching one controller start per
// cell and waiting for the unit's completion under a watchdog, with abort support.
module matrix_sweep_scheduler
  import matrix_pkg::*;
#(
  parameter int maxWidthLen = 4,
  parameter int timeoutLen  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [UNIT_WIDTH-1:0]  cmd_unit,
  input  logic [maxWidthLen-1:0] cmd_xlast,
  input  logic [maxWidthLen-1:0] cmd_ylast,
  input  logic                   abort,
  input  logic                   unit_done,
  output logic                   start,
  output logic [UNIT_WIDTH-1:0]  index,
  output logic [maxWidthLen-1:0] x,
  output logic [maxWidthLen-1:0] y,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  // Watchdog value seen during the last permitted WAIT cycle (2^timeoutLen-2),
  // so the timeout fires once 2^timeoutLen-1 WAIT cycles have elapsed.
  localparam logic [timeoutLen-1:0] WDOG_LAST = {{(timeoutLen-1){1'b1}}, 1'b0};

  sched_state_e           state_q, state_d;
  unit_t                  unit_q, unit_d;
  logic [maxWidthLen-1:0] xlast_q, xlast_d;
  logic [maxWidthLen-1:0] ylast_q, ylast_d;
  logic [timeoutLen-1:0]  wdog_q, wdog_d;

  logic                   coordClear;
  logic                   coordAdvance;
  logic                   coordLast;
  logic [maxWidthLen-1:0] coordX;
  logic [maxWidthLen-1:0] coordY;

  matrix_coord_counter #(
    .maxWidthLen (maxWidthLen)
  ) u_coord (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (coordClear),
    .advance_i (coordAdvance),
    .xlast_i   (xlast_q),
    .ylast_i   (ylast_q),
    .x_o       (coordX),
    .y_o       (coordY),
    .last_o    (coordLast)
  );

  // Next-state logic: command capture, per-cell handshake, watchdog and abort.
  always_comb begin
    state_d      = state_q;
    unit_d       = unit_q;
    xlast_d      = xlast_q;
    ylast_d      = ylast_q;
    wdog_d       = wdog_q;
    coordClear   = 1'b0;
    coordAdvance = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          unit_d     = cmd_unit;
          xlast_d    = cmd_xlast;
          ylast_d    = cmd_ylast;
          coordClear = 1'b1;
          state_d    = unitIsLegal(cmd_unit) ? ST_ISSUE : ST_ERR;
        end
      end
      ST_ISSUE: begin
        wdog_d  = '0;
        state_d = abort ? ST_IDLE : ST_WAIT;
      end
      ST_WAIT: begin
        wdog_d = wdog_q + 1'b1;
        if (abort) begin
          state_d = ST_IDLE;
        end else if (unit_done) begin
          if (coordLast) begin
            state_d = ST_DONE;
          end else begin
            coordAdvance = 1'b1;
            state_d      = ST_ISSUE;
          end
        end else if (wdog_q == WDOG_LAST) begin
          state_d = ST_ERR;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      ST_ERR: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, latched command and watchdog registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      unit_q  <= UNIT_NONE;
      xlast_q <= '0;
      ylast_q <= '0;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      unit_q  <= unit_d;
      xlast_q <= xlast_d;
      ylast_q <= ylast_d;
      wdog_q  <= wdog_d;
    end
  end

  // Moore output decode; the controller sees a unit and cell only during ISSUE.
  assign cmd_ready = (state_q == ST_IDLE);
  assign start     = (state_q == ST_ISSUE);
  assign index     = (state_q == ST_ISSUE) ? unit_q : UNIT_NONE;
  assign x         = (state_q == ST_ISSUE) ? coordX : '0;
  assign y         = (state_q == ST_ISSUE) ? coordY : '0;
  assign busy      = (state_q == ST_ISSUE) || (state_q == ST_WAIT) || (state_q == ST_DONE);
  assign done      = (state_q == ST_DONE);
  assign err       = (state_q == ST_ERR);

endmodule

// File: tb/tb_matrix_sweep_scheduler.sv
// Self-checking bench for matrix_sweep_scheduler: table of sweeps, hand-written
// corner sequences and random commands, all judged against a raster-walk model.
module tb_matrix_sweep_scheduler;

  localparam int MW         = 4;
  localparam int TO         = 4;
  localparam int WAIT_LIMIT = (1 << TO) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [2:0]    cmd_unit = '0;
  logic [MW-1:0] cmd_xlast = '0;
  logic [MW-1:0] cmd_ylast = '0;
  logic          abort = 1'b0;
  logic          unit_done = 1'b0;
  logic          start;
  logic [2:0]    index;
  logic [MW-1:0] x;
  logic [MW-1:0] y;
  logic          busy;
  logic          done;
  logic          err;

  matrix_sweep_scheduler #(
    .maxWidthLen (MW),
    .timeoutLen  (TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_unit  (cmd_unit),
    .cmd_xlast (cmd_xlast),
    .cmd_ylast (cmd_ylast),
    .abort     (abort),
    .unit_done (unit_done),
    .start     (start),
    .index     (index),
    .x         (x),
    .y         (y),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string name;
    int    unit;
    int    xl;
    int    yl;
    int    lat;
    int    abortAt;
    int    expStarts;
    int    expDone;
    int    expErr;
  } vec_t;

  int   checks   = 0;
  int   failures = 0;
  int   expCells[$];
  int   gotCells[$];
  vec_t tbl[$];

  task automatic checkOutput(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  function automatic vec_t mkVec(input string name, input int unit, input int xl, input int yl,
                                 input int lat, input int abortAt, input int eS, input int eD,
                                 input int eE);
    vec_t v;
    v.name = name; v.unit = unit; v.xl = xl; v.yl = yl; v.lat = lat; v.abortAt = abortAt;
    v.expStarts = eS; v.expDone = eD; v.expErr = eE;
    return v;
  endfunction

  function automatic int cellCode(input int u, input int cx, input int cy);
    return u * 256 + cy * 16 + cx;
  endfunction

  // Reference: full raster list of cells, truncated by abort or a never-answered cell.
  task automatic buildModel(input vec_t v, output int eStarts, output int eDone, output int eErr);
    expCells.delete();
    eDone = 0;
    eErr  = 0;
    if (v.unit < 1 || v.unit > 5) begin
      eErr    = 1;
      eStarts = 0;
      return;
    end
    for (int yy = 0; yy <= v.yl; yy++)
      for (int xx = 0; xx <= v.xl; xx++)
        expCells.push_back(cellCode(v.unit, xx, yy));
    if (v.abortAt >= 0) begin
      while (expCells.size() > v.abortAt + 1) void'(expCells.pop_back());
    end else if (v.lat == 0 || v.lat > WAIT_LIMIT) begin
      while (expCells.size() > 1) void'(expCells.pop_back());
      eErr = 1;
    end else begin
      eDone = 1;
    end
    eStarts = expCells.size();
  endtask

  task automatic compareCells(input string name);
    checkOutput({name, "_ncells"}, gotCells.size(), expCells.size());
    for (int i = 0; i < gotCells.size() && i < expCells.size(); i++)
      checkOutput({name, "_cell"}, gotCells[i], expCells[i]);
  endtask

  // Issue one command and act as the addressed unit until the scheduler is idle again.
  task automatic applyStimulus(input vec_t v);
    int mS, mD, mE;
    int acceptCyc, firstStartCyc, lastStartCyc, lastUdCyc, doneCyc, errCyc, readyCyc, abortCyc;
    int nStarts, nDone, nErr, cnt, budget, badOut;
    bit waiting, aborted, finished, firstWait;
    acceptCyc = 0; firstStartCyc = 0; lastStartCyc = 0; lastUdCyc = 0; doneCyc = 0;
    errCyc = 0; readyCyc = 0; abortCyc = 0; nStarts = 0; nDone = 0; nErr = 0; cnt = 0;
    budget = 0; badOut = 0; waiting = 0; aborted = 0; finished = 0; firstWait = 0;
    buildModel(v, mS, mD, mE);
    gotCells.delete();
    @(negedge clk);
    checkOutput({v.name, "_ready"}, int'(cmd_ready), 1);
    cmd_valid = 1'b1;
    cmd_unit  = v.unit[2:0];
    cmd_xlast = v.xl[MW-1:0];
    cmd_ylast = v.yl[MW-1:0];
    acceptCyc = cyc;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_unit  = 3'($urandom);
    cmd_xlast = MW'($urandom);
    cmd_ylast = MW'($urandom);
    while (!finished && budget < 2000) begin
      if (start) begin
        nStarts++;
        gotCells.push_back(cellCode(int'(index), int'(x), int'(y)));
        if (nStarts == 1) firstStartCyc = cyc;
        lastStartCyc = cyc;
        if (!busy || done || err || cmd_ready) badOut++;
        unit_done = 1'b0;
        waiting   = 1'b1;
        firstWait = 1'b1;
        cnt       = v.lat;
      end else begin
        if (index != 0 || x != 0 || y != 0) badOut++;
        unit_done = 1'b0;
        abort     = 1'b0;
        if (done) begin nDone++; doneCyc = cyc; if (!busy) badOut++; end
        if (err)  begin nErr++;  errCyc  = cyc; if (busy)  badOut++; end
        if (cmd_ready && (nDone > 0 || nErr > 0 || aborted)) begin
          readyCyc = cyc;
          finished = 1'b1;
          if (busy) badOut++;
        end else if (waiting) begin
          if (firstWait && (nStarts - 1) == v.abortAt) begin
            abort    = 1'b1;
            aborted  = 1'b1;
            abortCyc = cyc;
            waiting  = 1'b0;
          end else if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
              unit_done = 1'b1;
              lastUdCyc = cyc;
              waiting   = 1'b0;
            end
          end
          firstWait = 1'b0;
        end
      end
      if (!finished) begin
        @(negedge clk);
        budget++;
      end
    end
    unit_done = 1'b0;
    abort     = 1'b0;
    checkOutput({v.name, "_finished"}, int'(finished), 1);
    checkOutput({v.name, "_starts"}, nStarts, v.expStarts);
    checkOutput({v.name, "_done"}, nDone, v.expDone);
    checkOutput({v.name, "_err"}, nErr, v.expErr);
    checkOutput({v.name, "_outputs"}, badOut, 0);
    compareCells(v.name);
    if (nStarts > 0) checkOutput({v.name, "_first_start_lat"}, firstStartCyc - acceptCyc, 1);
    if (nDone > 0) begin
      checkOutput({v.name, "_done_lat"}, doneCyc - lastUdCyc, 1);
      checkOutput({v.name, "_ready_after_done"}, readyCyc - doneCyc, 1);
    end
    if (nErr > 0) begin
      if (nStarts == 0) checkOutput({v.name, "_err_lat"}, errCyc - acceptCyc, 1);
      else checkOutput({v.name, "_timeout_lat"}, errCyc - lastStartCyc, WAIT_LIMIT + 1);
      checkOutput({v.name, "_ready_after_err"}, readyCyc - errCyc, 1);
    end
    if (aborted) checkOutput({v.name, "_abort_lat"}, readyCyc - abortCyc, 1);
  endtask

  task automatic waitStart(input string name);
    int n;
    n = 0;
    while (!start && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, "_start_seen"}, int'(start), 1);
  endtask

  // Absolute guard so the run ends even if a sweep loop misbehaves.
  initial begin
    #500000;
    $display("[TB] FAIL global_timeout got=running expected=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    vec_t v;
    int   a, n, doneC, eS, eD, eE;

    // Reset state
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset_ready", int'(cmd_ready), 1);
    checkOutput("reset_outputs", int'({start, index, x, y, busy, done, err}), 0);
    rst = 1'b1;
    @(negedge clk);

    // Directed sweeps: name, unit, xlast, ylast, latency, abortAt, starts, done, err
    tbl.push_back(mkVec("u2_2x2",        2, 1, 1,  3, -1,  4, 1, 0));
    tbl.push_back(mkVec("illegal6",      6, 1, 1,  3, -1,  0, 0, 1));
    tbl.push_back(mkVec("illegal0",      0, 2, 0,  3, -1,  0, 0, 1));
    tbl.push_back(mkVec("illegal7",      7, 0, 0,  1, -1,  0, 0, 1));
    tbl.push_back(mkVec("timeout_1x1",   1, 0, 0,  0, -1,  1, 0, 1));
    tbl.push_back(mkVec("single_cell",   3, 0, 0,  1, -1,  1, 1, 0));
    tbl.push_back(mkVec("abort_at_2",    5, 3, 0,  3,  2,  3, 0, 0));
    tbl.push_back(mkVec("after_abort",   4, 3, 0,  1, -1,  4, 1, 0));
    tbl.push_back(mkVec("max_width",     5, 15, 0, 1, -1, 16, 1, 0));
    tbl.push_back(mkVec("max_height",    1, 0, 15, 2, -1, 16, 1, 0));
    tbl.push_back(mkVec("slow_3x3",      5, 2, 2, 14, -1,  9, 1, 0));
    tbl.push_back(mkVec("done_at_limit", 3, 0, 0, 15, -1,  1, 1, 0));
    tbl.push_back(mkVec("past_limit",    2, 1, 0, 16, -1,  1, 0, 1));
    foreach (tbl[i]) applyStimulus(tbl[i]);

    // unit_done held high: one cell every two cycles, ISSUE-cycle completions ignored
    v = mkVec("hold_high", 4, 1, 1, 1, -1, 4, 1, 0);
    buildModel(v, eS, eD, eE);
    gotCells.delete();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_unit = 3'd4; cmd_xlast = 4'd1; cmd_ylast = 4'd1; unit_done = 1'b1;
    a = cyc;
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    doneC = -1;
    for (int i = 0; i < 12; i++) begin
      if (start) begin
        gotCells.push_back(cellCode(int'(index), int'(x), int'(y)));
        checkOutput("hold_start_cycle", cyc - a, 1 + 2 * n);
        n++;
      end
      if (done) doneC = cyc;
      @(negedge clk);
    end
    unit_done = 1'b0;
    checkOutput("hold_starts", n, 4);
    checkOutput("hold_done_cycle", doneC - a, 9);
    checkOutput("hold_idle_ready", int'(cmd_ready), 1);
    compareCells("hold");

    // Reset in the WAIT of cell (1,0), then a fresh sweep from (0,0)
    @(negedge clk);
    cmd_valid = 1'b1; cmd_unit = 3'd2; cmd_xlast = 4'd2; cmd_ylast = 4'd1;
    @(negedge clk);
    cmd_valid = 1'b0;
    waitStart("rst_cell0");
    @(negedge clk);
    @(negedge clk);
    unit_done = 1'b1;
    @(negedge clk);
    unit_done = 1'b0;
    waitStart("rst_cell1");
    checkOutput("rst_cell1_x", int'(x), 1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("midreset_outputs", int'({start, index, x, y, busy, done, err}), 0);
    checkOutput("midreset_ready", int'(cmd_ready), 1);
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(mkVec("post_reset", 2, 2, 1, 2, -1, 6, 1, 0));

    // Random commands judged by the model
    for (int r = 0; r < 20; r++) begin
      v.name    = "rand";
      v.unit    = int'($urandom_range(0, 7));
      v.xl      = int'($urandom_range(0, 3));
      v.yl      = int'($urandom_range(0, 3));
      v.lat     = int'($urandom_range(1, 8));
      v.abortAt = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, (v.xl + 1) * (v.yl + 1) - 1)) : -1;
      buildModel(v, eS, eD, eE);
      v.expStarts = eS;
      v.expDone   = eD;
      v.expErr    = eE;
      applyStimulus(v);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
